// File: rtl/gp_dispatch_pkg.sv
// Shared types and constants for the triangle dispatcher and its vertex gather unit.
package gp_dispatch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LAUNCH,
      WAIT_DONE,
      WRITE,
      FINISH
   } state_t;

   localparam int         VERTS_PER_TRI = 9;
   localparam logic [3:0] COLOR_FAULT   = 4'hF;

endpackage

// File: rtl/vertex_gather.sv
// Streams the nine vertex words of one triangle out of vertex memory into
// capture slots; o_done_fetch marks the cycle the last word lands.
module vertex_gather
   import gp_dispatch_pkg::*;
#(
   parameter int ADDR_W = 12
)(
   input  logic                           clk,
   input  logic                           sreset,
   input  logic                           i_fetch,
   input  logic [ADDR_W-1:0]              i_base,
   input  logic [31:0]                    i_vmem_data,
   output logic                           o_vmem_rd,
   output logic [ADDR_W-1:0]              o_vmem_addr,
   output logic                           o_done_fetch,
   output logic [VERTS_PER_TRI-1:0][31:0] o_verts
);

   logic [3:0]                     r_k;
   logic [VERTS_PER_TRI-1:0][31:0] r_verts;
   logic                           w_rd;
   logic                           w_done;

   // r_k issues read k on slot cycles 0..8 and retires word k-1 on cycles 1..9.
   assign w_rd         = i_fetch && (r_k < 4'(VERTS_PER_TRI));
   assign w_done       = i_fetch && (r_k == 4'(VERTS_PER_TRI));
   assign o_vmem_rd    = w_rd;
   assign o_vmem_addr  = w_rd ? (i_base + ADDR_W'(r_k)) : '0;
   assign o_done_fetch = w_done;
   assign o_verts      = r_verts;

   always_ff @(posedge clk) begin
      if (sreset) begin
         r_k     <= '0;
         r_verts <= '0;
      end else begin
         if (!i_fetch || w_done) begin
            r_k <= '0;
         end else begin
            r_k <= r_k + 4'd1;
         end
         if (i_fetch && (r_k != 4'd0)) begin
            r_verts[r_k - 4'd1] <= i_vmem_data;
         end
      end
   end

endmodule

// File: rtl/triangle_dispatcher.sv
// Shader-side initiator: fetches each triangle's vertices, launches the shader,
// waits for its color (with a watchdog) and writes it to the color buffer.
module triangle_dispatcher
   import gp_dispatch_pkg::*;
#(
   parameter int NUM_TRI_MAX = 256,
   parameter int TRI_W       = 8,
   parameter int ADDR_W      = 12,
   parameter int TIMEOUT     = 255
)(
   input  logic               clk,
   input  logic               sreset,
   input  logic               go,
   input  logic [TRI_W:0]     tri_count,
   output logic               busy,
   output logic               run_done,
   output logic               err,
   output logic               vmem_rd,
   output logic [ADDR_W-1:0]  vmem_addr,
   input  logic [31:0]        vmem_data,
   output logic               shd_start,
   output logic [2:0][31:0]   shd_p1,
   output logic [2:0][31:0]   shd_p2,
   output logic [2:0][31:0]   shd_p3,
   input  logic               shd_done,
   input  logic [3:0]         shd_color,
   output logic               cbuf_we,
   output logic [TRI_W-1:0]   cbuf_addr,
   output logic [3:0]         cbuf_data,
   output state_t             o_dbg_state
);

   localparam int              WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [TRI_W:0]  MAX_CNT = (TRI_W+1)'(NUM_TRI_MAX);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            r_state;
   logic [TRI_W:0]    r_count;
   logic [TRI_W-1:0]  r_idx;
   logic [ADDR_W-1:0] r_base;
   logic [WD_W-1:0]   r_wd;
   logic              r_err;
   logic              r_shd_start;
   logic              r_cbuf_we;
   logic [TRI_W-1:0]  r_cbuf_addr;
   logic [3:0]        r_color;
   logic              r_run_done;

   logic [TRI_W:0]                 w_clamped;
   logic                           w_last;
   logic                           w_done_fetch;
   logic [VERTS_PER_TRI-1:0][31:0] w_verts;

   assign w_clamped = (tri_count > MAX_CNT) ? MAX_CNT : tri_count;
   assign w_last    = (({1'b0, r_idx} + (TRI_W+1)'(1)) == r_count);

   vertex_gather #(
      .ADDR_W (ADDR_W)
   ) u_gather (
      .clk          (clk),
      .sreset       (sreset),
      .i_fetch      (r_state == FETCH),
      .i_base       (r_base),
      .i_vmem_data  (vmem_data),
      .o_vmem_rd    (vmem_rd),
      .o_vmem_addr  (vmem_addr),
      .o_done_fetch (w_done_fetch),
      .o_verts      (w_verts)
   );

   // Shader handshake: shd_start is a single-cycle request with p1..p3 held
   // stable; shd_done is a single-cycle reply, honoured only in WAIT_DONE.
   always_ff @(posedge clk) begin
      if (sreset) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_idx       <= '0;
         r_base      <= '0;
         r_wd        <= '0;
         r_err       <= 1'b0;
         r_shd_start <= 1'b0;
         r_cbuf_we   <= 1'b0;
         r_cbuf_addr <= '0;
         r_color     <= '0;
         r_run_done  <= 1'b0;
      end else begin
         r_shd_start <= 1'b0;
         r_cbuf_we   <= 1'b0;
         r_run_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go) begin
                  r_count <= w_clamped;
                  r_err   <= 1'b0;
                  r_idx   <= '0;
                  r_base  <= '0;
                  if (w_clamped == '0) begin
                     r_state    <= FINISH;
                     r_run_done <= 1'b1;
                  end else begin
                     r_state <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (w_done_fetch) begin
                  r_state     <= LAUNCH;
                  r_shd_start <= 1'b1;
               end
            end
            LAUNCH: begin
               r_state <= WAIT_DONE;
               r_wd    <= '0;
            end
            WAIT_DONE: begin
               // A done arriving on the final watchdog cycle still wins.
               if (shd_done) begin
                  r_color     <= shd_color;
                  r_cbuf_we   <= 1'b1;
                  r_cbuf_addr <= r_idx;
                  r_state     <= WRITE;
               end else if (r_wd == WD_LAST) begin
                  r_color     <= COLOR_FAULT;
                  r_err       <= 1'b1;
                  r_cbuf_we   <= 1'b1;
                  r_cbuf_addr <= r_idx;
                  r_state     <= WRITE;
               end else begin
                  r_wd <= r_wd + WD_W'(1);
               end
            end
            WRITE: begin
               if (w_last) begin
                  r_state    <= FINISH;
                  r_run_done <= 1'b1;
               end else begin
                  r_idx   <= r_idx + TRI_W'(1);
                  r_base  <= r_base + ADDR_W'(VERTS_PER_TRI);
                  r_state <= FETCH;
               end
            end
            FINISH: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign run_done    = r_run_done;
   assign err         = r_err;
   assign shd_start   = r_shd_start;
   assign shd_p1      = w_verts[2:0];
   assign shd_p2      = w_verts[5:3];
   assign shd_p3      = w_verts[8:6];
   assign cbuf_we     = r_cbuf_we;
   assign cbuf_addr   = r_cbuf_addr;
   assign cbuf_data   = r_color;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher: vertex memory and shader models,
// event logger, write scoreboard and a one-line summary.
module tb_triangle_dispatcher;
   import gp_dispatch_pkg::*;

   logic            clk = 1'b0;
   logic            sreset;
   logic            go;
   logic [8:0]      tri_count;
   logic            busy, run_done, err, vmem_rd;
   logic [11:0]     vmem_addr;
   logic [31:0]     vmem_data;
   logic            shd_start;
   logic [2:0][31:0] shd_p1, shd_p2, shd_p3;
   logic            shd_done;
   logic [3:0]      shd_color;
   logic            cbuf_we;
   logic [7:0]      cbuf_addr;
   logic [3:0]      cbuf_data;
   state_t          dbg_state;

   triangle_dispatcher dut (
      .clk         (clk),
      .sreset      (sreset),
      .go          (go),
      .tri_count   (tri_count),
      .busy        (busy),
      .run_done    (run_done),
      .err         (err),
      .vmem_rd     (vmem_rd),
      .vmem_addr   (vmem_addr),
      .vmem_data   (vmem_data),
      .shd_start   (shd_start),
      .shd_p1      (shd_p1),
      .shd_p2      (shd_p2),
      .shd_p3      (shd_p3),
      .shd_done    (shd_done),
      .shd_color   (shd_color),
      .cbuf_we     (cbuf_we),
      .cbuf_addr   (cbuf_addr),
      .cbuf_data   (cbuf_data),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1);
   end

   // ---------------- memory and shader models ----------------
   logic [31:0] mem [4096];
   int          sh_pend = 0;
   int          sh_cnt = 0;
   int          sh_base = 0;
   int          sh_delay = 3;
   bit          sh_en = 1'b1;
   logic [3:0]  sh_color_r = 4'h0;
   logic [3:0]  sh_tbl [16];
   logic        spur_done = 1'b0;

   assign shd_done  = (sh_pend == 1) || spur_done;
   assign shd_color = sh_color_r;

   always @(posedge clk) begin
      vmem_data <= mem[vmem_addr];
      if (sreset) begin
         sh_pend <= 0;
      end else if (shd_start && sh_en) begin
         sh_pend    <= sh_delay;
         sh_color_r <= sh_tbl[(sh_cnt - sh_base) & 15];
      end else if (sh_pend != 0) begin
         sh_pend <= sh_pend - 1;
      end
      if (shd_start) sh_cnt <= sh_cnt + 1;
   end

   // ---------------- event logger ----------------
   int          run_id = 0;
   int          seen_id = 0;
   int          go_cyc = 0;
   logic [11:0] vaddr_q [$];
   logic [11:0] wr_q [$];
   int          wr_cyc_q [$];
   int          n_start = 0;
   int          n_rdone = 0;
   int          rdone_cyc = -1;
   logic        err_at_done = 1'b0;

   always @(negedge clk) begin
      if (run_id != seen_id) begin
         vaddr_q.delete();
         wr_q.delete();
         wr_cyc_q.delete();
         n_start   = 0;
         n_rdone   = 0;
         rdone_cyc = -1;
         seen_id   = run_id;
      end
      if (vmem_rd) vaddr_q.push_back(vmem_addr);
      if (cbuf_we) begin
         wr_q.push_back({cbuf_addr, cbuf_data});
         wr_cyc_q.push_back(cyc - go_cyc);
      end
      if (shd_start) n_start++;
      if (run_done) begin
         n_rdone++;
         rdone_cyc   = cyc - go_cyc;
         err_at_done = err;
      end
   end

   // ---------------- scoreboard ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [11:0] vaddr_at(input int i);
      if (i < vaddr_q.size()) return vaddr_q[i];
      return 12'hxxx;
   endfunction

   function automatic logic [11:0] wr_at(input int i);
      if (i < wr_q.size()) return wr_q[i];
      return 12'hxxx;
   endfunction

   function automatic int cyc_at(input int i);
      if (i < wr_cyc_q.size()) return wr_cyc_q[i];
      return -1;
   endfunction

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_wr"}, wr_at(i), exp_q[i]);
      end
      exp_q.delete();
   endtask

   task automatic check_sweep(input string tag, input int n);
      check({tag, "_vaddr_count"}, vaddr_q.size(), n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_vaddr"}, vaddr_at(i), i);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_run(input int n);
      @(negedge clk);
      run_id++;
      sh_base   = sh_cnt;
      go_cyc    = cyc;
      tri_count = 9'(n);
      go        = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_run(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (run_done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      check({tag, "_run_done_seen"}, seen, 1);
   endtask

   task automatic wait_rel(input int r);
      while ((cyc - go_cyc) < r) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      sreset = 1'b1;
      @(negedge clk);
      sreset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] fl [9];
   bit          seen6;
   int          r;

   initial begin
      fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
      for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      for (int i = 0; i < 9; i++) mem[i] = fl[i];
      for (int i = 0; i < 16; i++) sh_tbl[i] = 4'(i);
      sreset    = 1'b1;
      go        = 1'b0;
      tri_count = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_run_done", run_done, 0);
      check("rst_err", err, 0);
      check("rst_vmem_rd", vmem_rd, 0);
      check("rst_vmem_addr", vmem_addr, 0);
      check("rst_shd_start", shd_start, 0);
      check("rst_shd_p1", shd_p1, 0);
      check("rst_cbuf_we", cbuf_we, 0);
      check("rst_cbuf_addr", cbuf_addr, 0);
      check("rst_cbuf_data", cbuf_data, 0);
      check("rst_state", dbg_state, IDLE);
      sreset = 1'b0;

      // single triangle, done 3 cycles after start
      sh_en = 1'b1; sh_delay = 3; sh_tbl[0] = 4'h5;
      start_run(1);
      wait_run("t1", 100);
      check("t1_p1x", shd_p1[0], 32'h3F800000);
      check("t1_p1y", shd_p1[1], 32'h40000000);
      check("t1_p1z", shd_p1[2], 32'h40400000);
      check("t1_p2x", shd_p2[0], 32'h40800000);
      check("t1_p3x", shd_p3[0], 32'h40E00000);
      check("t1_p3y", shd_p3[1], 32'h41000000);
      check("t1_p3z", shd_p3[2], 32'h41100000);
      check_sweep("t1", 9);
      exp_q.push_back({8'd0, 4'h5});
      check_writes("t1");
      check("t1_wr_cycle", cyc_at(0), 15);
      check("t1_rdone_cycle", rdone_cyc, 16);
      check("t1_starts", n_start, 1);
      check("t1_busy_after", busy, 0);

      // three triangles, contiguous sweep
      sh_delay = 2; sh_tbl[0] = 4'h1; sh_tbl[1] = 4'h2; sh_tbl[2] = 4'h3;
      start_run(3);
      wait_run("t2", 200);
      check_sweep("t2", 27);
      exp_q.push_back({8'd0, 4'h1});
      exp_q.push_back({8'd1, 4'h2});
      exp_q.push_back({8'd2, 4'h3});
      check_writes("t2");
      check("t2_rdone_count", n_rdone, 1);
      check("t2_p3z", shd_p3[2], 32'hC0DE001A);

      // zero triangles
      start_run(0);
      wait_run("t3", 10);
      check("t3_rdone_cycle", rdone_cyc, 1);
      check("t3_vaddr_count", vaddr_q.size(), 0);
      check("t3_starts", n_start, 0);
      check("t3_wr_count", wr_q.size(), 0);

      // go while busy and a spurious done during FETCH are ignored
      sh_delay = 3; sh_tbl[0] = 4'h6; sh_tbl[1] = 4'h7;
      start_run(2);
      seen6 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         r = cyc - go_cyc;
         go        = (r == 5) || (r == 28);
         spur_done = (r == 3);
         if (run_done) begin
            seen6 = 1'b1;
            break;
         end
         @(negedge clk);
      end
      go = 1'b0;
      spur_done = 1'b0;
      @(negedge clk);
      check("t6_run_done_seen", seen6, 1);
      check_sweep("t6", 18);
      exp_q.push_back({8'd0, 4'h6});
      exp_q.push_back({8'd1, 4'h7});
      check_writes("t6");
      check("t6_wr0_cycle", cyc_at(0), 15);
      check("t6_wr1_cycle", cyc_at(1), 30);
      repeat (3) @(negedge clk);
      check("t6_rdone_count", n_rdone, 1);
      check("t6_idle_after", busy, 0);

      // shader never answers: watchdog faults both triangles
      sh_en = 1'b0;
      start_run(2);
      wait_run("t4", 1200);
      exp_q.push_back({8'd0, 4'hF});
      exp_q.push_back({8'd1, 4'hF});
      check_writes("t4");
      check("t4_wr0_cycle", cyc_at(0), 267);
      check("t4_wr1_cycle", cyc_at(1), 534);
      check("t4_rdone_cycle", rdone_cyc, 535);
      check("t4_err_at_done", err_at_done, 1);
      check("t4_err_sticky", err, 1);
      pulse_reset();
      check("t4_err_rst_clear", err, 0);

      start_run(1);
      wait_run("t4b", 600);
      check("t4b_err_set", err, 1);
      sh_en = 1'b1; sh_delay = 1; sh_tbl[0] = 4'h3;
      start_run(1);
      check("t4b_err_go_clear", err, 0);
      wait_run("t4b2", 100);
      check("t4b_err_end", err, 0);
      exp_q.push_back({8'd0, 4'h3});
      check_writes("t4b");

      // sreset mid-FETCH (slot 4) and mid-WAIT_DONE
      sh_en = 1'b0;
      start_run(2);
      wait_rel(5);
      sreset = 1'b1;
      @(negedge clk);
      sreset = 1'b0;
      check("t5a_busy", busy, 0);
      check("t5a_vmem_rd", vmem_rd, 0);
      check("t5a_shd_start", shd_start, 0);
      check("t5a_cbuf_we", cbuf_we, 0);
      check("t5a_p1", shd_p1, 0);
      check("t5a_p3", shd_p3, 0);
      check("t5a_state", dbg_state, IDLE);
      start_run(1);
      wait_rel(20);
      check("t5b_in_wait", dbg_state, WAIT_DONE);
      sreset = 1'b1;
      @(negedge clk);
      sreset = 1'b0;
      check("t5b_busy", busy, 0);
      check("t5b_shd_start", shd_start, 0);
      check("t5b_cbuf_we", cbuf_we, 0);
      check("t5b_p1", shd_p1, 0);
      check("t5b_err", err, 0);
      repeat (3) @(negedge clk);
      check("t5b_no_write", wr_q.size(), 0);
      check("t5b_still_idle", busy, 0);
      sh_en = 1'b1; sh_delay = 2; sh_tbl[0] = 4'h9;
      start_run(1);
      wait_run("t5c", 100);
      check_sweep("t5c", 9);
      exp_q.push_back({8'd0, 4'h9});
      check_writes("t5c");

      // count above maximum is clamped; minimum shader latency
      sh_delay = 1; sh_tbl[15] = 4'hC;
      start_run(300);
      wait_run("t7", 4000);
      check("t7_wr_count", wr_q.size(), 256);
      check("t7_vaddr_count", vaddr_q.size(), 2304);
      check("t7_vaddr_last", vaddr_at(2303), 2303);
      check("t7_wr_last", wr_at(255), {8'd255, 4'hC});
      check("t7_wr0_cycle", cyc_at(0), 13);
      check("t7_wr1_cycle", cyc_at(1), 26);
      check("t7_rdone_count", n_rdone, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
